// File: rtl/pes_graycode_counter.sv
// -----------------------------------------------------------------------------
// pes_graycode_counter
//
// Purpose:
//   Free-running, enable-gated Gray-code up-counter. An internal binary count
//   is advanced on each enabled clock edge. Its reflected-binary Gray encoding
//   is presented on a registered output. Because successive outputs differ in
//   exactly one bit, including on the wrap from all-ones back to zero, the
//   output is a safe source for clock-domain-crossing pointers.
//
// Parameters:
//   WIDTH       width of the binary count and of gray_count (must be >= 2)
//
// Ports:
//   clk         in   rising-edge clock; every state update happens on this edge
//   enable      in   count enable, sampled on the rising edge of clk
//   reset       in   synchronous, active-high reset; takes priority over enable
//   gray_count  out  WIDTH-bit Gray code of the current count, driven from a flop
// -----------------------------------------------------------------------------
module pes_graycode_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             enable,
  input  logic             reset,
  output logic [WIDTH-1:0] gray_count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;

  // Next-state logic. The Gray value is derived from the *incremented* binary
  // count, so gray_q always encodes the bin_q held after the same edge. There
  // is no extra pipeline stage between the count and its encoding.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    bin_d  = bin_q;
    gray_d = gray_q;
    if (enable) begin
      // Wraps naturally modulo 2^WIDTH; all-ones -> zero is also a one-bit
      // Gray step (MSB only), so no special case is needed.
      bin_d  = bin_q + ONE;
      gray_d = bin_d ^ (bin_d >> 1);
    end
  end

  // State registers. Reset is synchronous and overrides enable.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  // Output comes straight from the Gray register: no combinational path from
  // any input, so it cannot glitch between edges.
  assign gray_count = gray_q;

endmodule

// File: tb/tb_pes_graycode_counter.sv
// -----------------------------------------------------------------------------
// tb_pes_graycode_counter
//
// Self-checking bench for pes_graycode_counter (WIDTH = 8).
// The reference model keeps an integer event count and looks up the expected
// Gray code in a table built by the reflect-and-prefix construction of the
// reflected binary code. A compare process checks the DUT on every falling
// edge once reset has been seen. It also checks the one-bit-change and
// decode-to-successor properties. The main process drives directed vectors
// and checks hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_pes_graycode_counter;

  localparam int W    = 8;
  localparam int SIZE = 1 << W;

  typedef enum int {EDGE_NONE, EDGE_RST, EDGE_CNT, EDGE_HOLD} edge_e;

  logic         clk = 1'b0;
  logic         enable = 1'b1;
  logic         reset = 1'b1;
  logic [W-1:0] gray_count;

  int n_cmp  = 0;
  int n_fail = 0;

  pes_graycode_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .enable     (enable),
    .reset      (reset),
    .gray_count (gray_count)
  );

  always #2 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int gtab [SIZE];

  // Reflected binary code: the first half of the 2^(k+1) list is the
  // 2^k list. The second half is that list reversed with bit k set.
  initial begin
    gtab[0] = 0;
    for (int k = 0; k < W; k++) begin
      for (int j = 0; j < (1 << k); j++) begin
        gtab[(1 << k) + j] = (1 << k) | gtab[(1 << k) - 1 - j];
      end
    end
  end

  function automatic int gray_decode(input int g);
    int b;
    b = 0;
    for (int i = W - 1; i >= 0; i--) begin
      b |= (((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i;
    end
    return b;
  endfunction

  function automatic int popcount(input int v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += (v >> i) & 1;
    return c;
  endfunction

  int    m_cnt   = 0;
  bit    m_valid = 1'b0;
  edge_e m_edge  = EDGE_NONE;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt   <= 0;
      m_valid <= 1'b1;
      m_edge  <= EDGE_RST;
    end else if (enable) begin
      m_cnt  <= (m_cnt + 1) % SIZE;
      m_edge <= EDGE_CNT;
    end else begin
      m_edge <= EDGE_HOLD;
    end
  end

  // ---------------------------------------------------------------------------
  // Every-cycle compare, sampled on the falling edge
  // ---------------------------------------------------------------------------
  int prev_g    = 0;
  bit prev_ok   = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("model", gray_count, gtab[m_cnt]);
      if (prev_ok && m_edge == EDGE_CNT) begin
        check("one_bit_step", popcount(int'(gray_count) ^ prev_g), 1);
        check("decode_succ", gray_decode(int'(gray_count)),
              (gray_decode(prev_g) + 1) % SIZE);
      end else if (prev_ok && m_edge == EDGE_HOLD) begin
        check("hold_stable", gray_count, prev_g);
      end
      prev_g  = int'(gray_count);
      prev_ok = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic tick(input logic en, input logic rst);
    enable = en;
    reset  = rst;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq [8] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C};

  initial begin
    // Reset for two edges with enable high.
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check("reset_value", gray_count, 8'h00);

    // First eight counts after release.
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0);
      check($sformatf("seq[%0d]", i), gray_count, seq[i]);
    end

    // Hold at 0x06 for five edges, then resume to 0x07.
    tick(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    check("pre_hold", gray_count, 8'h06);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      check("hold", gray_count, 8'h06);
    end
    tick(1'b1, 1'b0);
    check("resume", gray_count, 8'h07);

    // Wrap: bin 0xFF -> gray 0x80, then 0x00, then 0x01.
    tick(1'b1, 1'b1);
    for (int i = 0; i < 255; i++) tick(1'b1, 1'b0);
    check("pre_wrap", gray_count, 8'h80);
    tick(1'b1, 1'b0);
    check("wrap", gray_count, 8'h00);
    tick(1'b1, 1'b0);
    check("post_wrap", gray_count, 8'h01);

    // Long run: 1000 enabled edges from reset -> bin 232 (0xE8) -> gray 0x9C.
    tick(1'b1, 1'b1);
    for (int i = 0; i < 1000; i++) tick(1'b1, 1'b0);
    check("long_run", gray_count, 8'h9C);

    // Reset mid-count at gray 0x1A (bin 19).
    tick(1'b1, 1'b1);
    for (int i = 0; i < 19; i++) tick(1'b1, 1'b0);
    check("at_1A", gray_count, 8'h1A);
    tick(1'b1, 1'b1);
    check("mid_reset", gray_count, 8'h00);
    tick(1'b1, 1'b0);
    check("after_mid_reset", gray_count, 8'h01);

    // Reset with enable low from a nonzero value, then idle.
    tick(1'b0, 1'b1);
    check("reset_en_low", gray_count, 8'h00);
    tick(1'b0, 1'b0);
    check("idle_after_reset", gray_count, 8'h00);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
